// File: rtl/mmio_tx_port.sv
// Memory-mapped serial transmit port: CPU stores bytes into a FIFO and they leave on tx_line as 8N1 frames.
// Latency: a store at edge N is counted at N, popped at N+1, start bit drives low after N+1; reads are combinational.
// Backpressure: none on the bus; a store into a full FIFO with no same-edge pop is dropped and sets sticky overflow.
module mmio_tx_port #(
   parameter int          DEPTH        = 4,
   parameter int          CLKS_PER_BIT = 4,
   parameter logic [31:0] BASE_ADDR    = 32'hFFFF0080
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] address,
   input  logic [31:0] data,
   input  logic        MemRead,
   input  logic        MemWrite,
   output wire  [31:0] rd_data,
   output logic        TxAddress,
   output logic        TxInterrupt,
   output logic        tx_line,
   output logic        tx_busy
);

   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNTW = AW + 1;
   localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0]   CNT_MAX   = CW'(CLKS_PER_BIT - 1);
   localparam logic [CNTW-1:0] COUNT_MAX = CNTW'(DEPTH);

   // Register offsets (word index from BASE_ADDR)
   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_ACK    = 2'd2;
   localparam logic [1:0] REG_CTRL   = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   // Bus decode
   logic [29:0] word_off;
   logic [1:0]  reg_sel;
   logic        wr_hit;
   logic        push_req;
   logic        ack_wr;
   logic        ctrl_wr;

   // FIFO
   logic [7:0]      mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CNTW-1:0] count;
   logic            empty;
   logic            full;
   logic            push_ok;
   logic            pop;

   // Serializer
   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic [2:0]    idx;
   logic [2:0]    idx_nxt;
   logic [7:0]    shift;
   logic          bit_end;
   logic          drain;

   // Control / interrupt
   logic        int_en;
   logic        int_pending;
   logic        overflow;
   logic [31:0] status;
   logic [31:0] rd_val;

   // Address bits below word granularity and upper store bits are don't-care
   logic unused_bits;
   assign unused_bits = ^{address[1:0], data[31:8]};

   assign word_off  = address[31:2] - BASE_ADDR[31:2];
   assign TxAddress = (word_off < 30'd4);
   assign reg_sel   = word_off[1:0];
   assign wr_hit    = MemWrite && TxAddress;
   assign push_req  = wr_hit && (reg_sel == REG_DATA);
   assign ack_wr    = wr_hit && (reg_sel == REG_ACK);
   assign ctrl_wr   = wr_hit && (reg_sel == REG_CTRL);

   assign empty   = (count == '0);
   assign full    = (count == COUNT_MAX);
   // A full FIFO still accepts when the serializer frees a slot on the same edge
   assign push_ok = push_req && (!full || pop);
   assign bit_end = (cnt == CNT_MAX);

   // FIFO storage; not reset, validity is tracked by count and pointers
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= data[7:0];
      end
   end

   // FIFO pointers, occupancy and sticky overflow flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push_ok, pop})
            2'b10:   count <= count + CNTW'(1);
            2'b01:   count <= count - CNTW'(1);
            default: count <= count;
         endcase
         if (push_req && !push_ok) begin
            overflow <= 1'b1;
         end else if (ack_wr) begin
            overflow <= 1'b0;
         end
      end
   end

   // Serializer next-state, bit timing and FIFO pop/drain strobes
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      idx_nxt   = idx;
      pop       = 1'b0;
      drain     = 1'b0;
      case (state)
         S_IDLE: begin
            if (!empty) begin
               pop       = 1'b1;
               state_nxt = S_START;
               cnt_nxt   = '0;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_nxt = S_DATA;
               cnt_nxt   = '0;
               idx_nxt   = 3'd0;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         S_DATA: begin
            if (bit_end) begin
               cnt_nxt = '0;
               if (idx == 3'd7) begin
                  state_nxt = S_STOP;
               end else begin
                  idx_nxt = idx + 3'd1;
               end
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         S_STOP: begin
            if (bit_end) begin
               cnt_nxt = '0;
               // Chain straight into the next start bit when more data waits
               if (!empty) begin
                  pop       = 1'b1;
                  state_nxt = S_START;
               end else begin
                  state_nxt = S_IDLE;
                  drain     = 1'b1;
               end
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
            idx_nxt   = 3'd0;
         end
      endcase
   end

   // Serializer state register and shift-register load on pop
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
         cnt   <= '0;
         idx   <= 3'd0;
         shift <= 8'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         idx   <= idx_nxt;
         if (pop) begin
            shift <= mem[rd_ptr];
         end
      end
   end

   // Line level is decoded from state so reset forces it high without a clock
   always_comb begin
      tx_line = 1'b1;
      case (state)
         S_START: tx_line = 1'b0;
         S_DATA:  tx_line = shift[idx];
         default: tx_line = 1'b1;
      endcase
   end

   assign tx_busy = (state != S_IDLE);

   // Interrupt enable and pending flag; a drain on the same edge as an ACK wins
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         int_en      <= 1'b0;
         int_pending <= 1'b0;
      end else begin
         if (ctrl_wr) begin
            int_en <= data[0];
         end
         if (drain && int_en) begin
            int_pending <= 1'b1;
         end else if (ack_wr) begin
            int_pending <= 1'b0;
         end
      end
   end

   assign TxInterrupt = int_pending;

   assign status = {16'd0, 8'(count), 3'd0, int_pending, overflow, tx_busy, full, empty};

   // Combinational read mux; only STATUS and CTRL return non-zero data
   always_comb begin
      rd_val = 32'd0;
      case (reg_sel)
         REG_STATUS: rd_val = status;
         REG_CTRL:   rd_val = {31'd0, int_en};
         default:    rd_val = 32'd0;
      endcase
   end

   assign rd_data = (MemRead && TxAddress) ? rd_val : 32'bz;

endmodule

// File: tb/tb_mmio_tx_port.sv
// Bench for mmio_tx_port: drives CPU-style loads/stores and decodes tx_line with a line receiver.
// The receiver turns each frame into a byte plus its start cycle; tasks compare against expected bytes/timing.
// A pull-up on the shared load bus makes a released rd_data read back as all ones.
module tb_mmio_tx_port;

   localparam int          DEPTH = 4;
   localparam int          CPB   = 4;
   localparam int          FRAME = 10 * CPB;
   localparam logic [31:0] BASE  = 32'hFFFF0080;
   localparam logic [31:0] A_DATA   = BASE;
   localparam logic [31:0] A_STATUS = BASE + 32'd4;
   localparam logic [31:0] A_ACK    = BASE + 32'd8;
   localparam logic [31:0] A_CTRL   = BASE + 32'd12;
   localparam logic [31:0] BUS_FREE = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] address = 32'd0;
   logic [31:0] data = 32'd0;
   logic        MemRead = 1'b0;
   logic        MemWrite = 1'b0;
   tri1  [31:0] rd_data;
   logic        TxAddress;
   logic        TxInterrupt;
   logic        tx_line;
   logic        tx_busy;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int last_store_cyc = 0;

   logic [7:0] rx_q[$];
   int         rx_start[$];
   bit         rx_bad[$];
   bit         mon_en = 1'b1;

   mmio_tx_port #(
      .DEPTH(DEPTH),
      .CLKS_PER_BIT(CPB),
      .BASE_ADDR(BASE)
   ) dut (
      .clk(clk),
      .reset(reset),
      .address(address),
      .data(data),
      .MemRead(MemRead),
      .MemWrite(MemWrite),
      .rd_data(rd_data),
      .TxAddress(TxAddress),
      .TxInterrupt(TxInterrupt),
      .tx_line(tx_line),
      .tx_busy(tx_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Line receiver: every bit must hold CPB samples; records byte, start cycle, framing error
   initial begin : receiver
      logic [9:0] bits;
      bit bad;
      bit abort;
      int st;
      forever begin
         @(negedge clk);
         if (mon_en && reset && tx_line === 1'b0) begin
            bits = '0;
            bad = 1'b0;
            abort = 1'b0;
            st = cyc;
            for (int b = 0; b < 10; b++) begin
               for (int c = 0; c < CPB; c++) begin
                  if (b != 0 || c != 0) @(negedge clk);
                  if (!mon_en || !reset) abort = 1'b1;
                  if (c == 0) bits[b] = tx_line;
                  else if (tx_line !== bits[b]) bad = 1'b1;
               end
            end
            if (!abort) begin
               rx_q.push_back(bits[8:1]);
               rx_start.push_back(st);
               rx_bad.push_back(bad || bits[0] !== 1'b0 || bits[9] !== 1'b1);
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      last_store_cyc = cyc;
      address = a;
      data = d;
      MemWrite = 1'b1;
      @(posedge clk);
      #1 MemWrite = 1'b0;
   endtask

   task automatic read(input logic [31:0] a, output logic [31:0] v, output logic sel);
      @(negedge clk);
      address = a;
      MemRead = 1'b1;
      #1 v = rd_data;
      sel = TxAddress;
      #1 MemRead = 1'b0;
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic wait_drain(input int budget, input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (tx_busy && n < budget);
      n_checks++;
      if (tx_busy) $display("FAIL %s_drain_timeout: busy still %b after %0d cycles, want 0", tag, tx_busy, n);
      else n_pass++;
      repeat (2) @(negedge clk);
   endtask

   task automatic clear_rx();
      rx_q.delete();
      rx_start.delete();
      rx_bad.delete();
   endtask

   // Checks received frames against the expected byte list, contiguous from first_start
   task automatic check_frames(input logic [7:0] exp_b[$], input int first_start, input string tag);
      n_checks++;
      if (rx_q.size() != exp_b.size())
         $display("FAIL %s_frame_count: got %0d frames want %0d", tag, rx_q.size(), exp_b.size());
      else n_pass++;
      for (int k = 0; k < exp_b.size() && k < rx_q.size(); k++) begin
         n_checks++;
         if (rx_q[k] !== exp_b[k] || rx_bad[k] || rx_start[k] != first_start + FRAME * k)
            $display("FAIL %s_frame%0d: got byte %h bad %0d start %0d want byte %h start %0d",
                     tag, k, rx_q[k], rx_bad[k], rx_start[k], exp_b[k], first_start + FRAME * k);
         else n_pass++;
      end
   endtask

   task automatic test_reset();
      logic [31:0] v;
      logic sel;
      reset = 1'b0;
      #1;
      n_checks++;
      if (tx_line !== 1'b1 || tx_busy !== 1'b0 || TxInterrupt !== 1'b0)
         $display("FAIL reset_outputs: got line %b busy %b int %b want 1 0 0", tx_line, tx_busy, TxInterrupt);
      else n_pass++;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (5) @(negedge clk);
      // Pulse reset again mid-simulation while idle
      #2 reset = 1'b0;
      #2 reset = 1'b1;
      read(A_STATUS, v, sel);
      n_checks++;
      if (v !== 32'h0000_0001 || sel !== 1'b1)
         $display("FAIL reset_status: got %h sel %b want 00000001 sel 1", v, sel);
      else n_pass++;
      @(negedge clk);
      address = A_STATUS;
      MemRead = 1'b0;
      #1;
      n_checks++;
      if (rd_data !== BUS_FREE || tx_line !== 1'b1)
         $display("FAIL reset_bus_released: got rd_data %h line %b want %h line 1", rd_data, tx_line, BUS_FREE);
      else n_pass++;
   endtask

   task automatic test_single_byte();
      logic [31:0] v;
      logic sel;
      logic [7:0] exp_b[$];
      int s;
      clear_rx();
      store(A_DATA, 32'hDEAD_BEA5);
      s = last_store_cyc;
      read(A_STATUS, v, sel);
      n_checks++;
      if (v !== 32'h0000_0100)
         $display("FAIL single_status_after_store: got %h want 00000100", v);
      else n_pass++;
      wait_cyc(s + 2 + FRAME - 1);
      n_checks++;
      if (tx_busy !== 1'b1 || tx_line !== 1'b1)
         $display("FAIL single_last_stop_cycle: got busy %b line %b want 1 1", tx_busy, tx_line);
      else n_pass++;
      wait_cyc(s + 2 + FRAME);
      n_checks++;
      if (tx_busy !== 1'b0 || tx_line !== 1'b1)
         $display("FAIL single_busy_clears: got busy %b line %b want 0 1", tx_busy, tx_line);
      else n_pass++;
      exp_b.push_back(8'hA5);
      check_frames(exp_b, s + 2, "single");
   endtask

   task automatic test_back_to_back();
      logic [31:0] v;
      logic sel;
      logic [7:0] exp_b[$];
      int s0;
      clear_rx();
      store(A_DATA, 32'h01);
      s0 = last_store_cyc;
      store(A_DATA, 32'h02);
      store(A_DATA, 32'h03);
      read(A_STATUS, v, sel);
      n_checks++;
      if (v[15:8] !== 8'd2 || v !== 32'h0000_0204)
         $display("FAIL b2b_status_count: got %h want 00000204", v);
      else n_pass++;
      wait_cyc(s0 + 2 + 3 * FRAME + 1);
      exp_b = '{8'h01, 8'h02, 8'h03};
      check_frames(exp_b, s0 + 2, "b2b");
   endtask

   task automatic test_random();
      logic [7:0] exp_b[$];
      int first_s;
      int n;
      logic [7:0] b;
      for (int it = 0; it < 6; it++) begin
         clear_rx();
         exp_b.delete();
         n = $urandom_range(1, DEPTH);
         first_s = 0;
         for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            b = 8'($urandom);
            store(A_DATA, {24'($urandom), b});
            if (k == 0) first_s = last_store_cyc;
            exp_b.push_back(b);
         end
         wait_cyc(last_store_cyc + 3);
         wait_drain(DEPTH * FRAME + 20, "random");
         check_frames(exp_b, first_s + 2, "random");
      end
   endtask

   task automatic test_overflow();
      logic [31:0] v;
      logic sel;
      logic [7:0] exp_b[$];
      logic [7:0] b;
      int s;
      clear_rx();
      store(A_DATA, 32'h5A);
      s = last_store_cyc;
      exp_b.push_back(8'h5A);
      wait_cyc(s + 4);
      for (int k = 0; k <= DEPTH; k++) begin
         b = 8'($urandom);
         store(A_DATA, {24'd0, b});
         if (k < DEPTH) exp_b.push_back(b);
      end
      read(A_STATUS, v, sel);
      n_checks++;
      if (v !== ((32'(DEPTH) << 8) | 32'h0000_000E))
         $display("FAIL ovf_status_full: got %h want %h", v, (32'(DEPTH) << 8) | 32'h0000_000E);
      else n_pass++;
      store(A_ACK, 32'h0);
      store(A_STATUS, 32'hFFFF_FFFF);
      read(A_STATUS, v, sel);
      n_checks++;
      if (v !== ((32'(DEPTH) << 8) | 32'h0000_0006))
         $display("FAIL ovf_ack_clears: got %h want %h", v, (32'(DEPTH) << 8) | 32'h0000_0006);
      else n_pass++;
      read(A_DATA, v, sel);
      n_checks++;
      if (v !== 32'd0 || sel !== 1'b1)
         $display("FAIL ovf_data_reads_zero: got %h sel %b want 00000000 sel 1", v, sel);
      else n_pass++;
      wait_drain((DEPTH + 2) * FRAME, "ovf");
      check_frames(exp_b, s + 2, "ovf");
   endtask

   task automatic test_interrupt();
      logic [31:0] v;
      logic sel;
      int s;
      store(A_CTRL, 32'h1);
      read(A_CTRL, v, sel);
      n_checks++;
      if (v !== 32'h1)
         $display("FAIL int_ctrl_read: got %h want 00000001", v);
      else n_pass++;
      store(A_DATA, 32'hC3);
      s = last_store_cyc;
      wait_cyc(s + 2 + FRAME - 1);
      n_checks++;
      if (TxInterrupt !== 1'b0)
         $display("FAIL int_before_drain: got %b want 0", TxInterrupt);
      else n_pass++;
      // ACK lands on the same edge as the drain
      address = A_ACK;
      data = 32'h0;
      MemWrite = 1'b1;
      @(posedge clk);
      #1 MemWrite = 1'b0;
      n_checks++;
      if (TxInterrupt !== 1'b1)
         $display("FAIL int_set_wins_over_ack: got %b want 1", TxInterrupt);
      else n_pass++;
      read(A_STATUS, v, sel);
      n_checks++;
      if (v !== 32'h0000_0011)
         $display("FAIL int_status_pending: got %h want 00000011", v);
      else n_pass++;
      store(A_CTRL, 32'h0);
      n_checks++;
      if (TxInterrupt !== 1'b1)
         $display("FAIL int_en_clear_keeps_pending: got %b want 1", TxInterrupt);
      else n_pass++;
      store(A_ACK, 32'h0);
      n_checks++;
      if (TxInterrupt !== 1'b0)
         $display("FAIL int_ack_clears: got %b want 0", TxInterrupt);
      else n_pass++;
      store(A_DATA, 32'h7E);
      wait_cyc(last_store_cyc + 3);
      wait_drain(FRAME + 10, "int_dis");
      store(A_CTRL, 32'h1);
      n_checks++;
      if (TxInterrupt !== 1'b0)
         $display("FAIL int_disabled_drain_lost: got %b want 0", TxInterrupt);
      else n_pass++;
      store(A_CTRL, 32'h0);
   endtask

   task automatic test_decode_reset();
      logic [31:0] v;
      logic sel;
      int s;
      read(32'hFFFF_0090, v, sel);
      n_checks++;
      if (sel !== 1'b0 || v !== BUS_FREE)
         $display("FAIL dec_above_range: got sel %b data %h want sel 0 data %h", sel, v, BUS_FREE);
      else n_pass++;
      read(32'hFFFF_007C, v, sel);
      n_checks++;
      if (sel !== 1'b0 || v !== BUS_FREE)
         $display("FAIL dec_below_range: got sel %b data %h want sel 0 data %h", sel, v, BUS_FREE);
      else n_pass++;
      read(32'hFFFF_0085, v, sel);
      n_checks++;
      if (sel !== 1'b1 || v !== 32'h0000_0001)
         $display("FAIL dec_low_bits_ignored: got sel %b data %h want sel 1 data 00000001", sel, v);
      else n_pass++;
      clear_rx();
      store(A_DATA, 32'h00);
      s = last_store_cyc;
      store(A_DATA, 32'h11);
      wait_cyc(s + 2 + CPB + CPB + 2);
      n_checks++;
      if (tx_line !== 1'b0 || tx_busy !== 1'b1)
         $display("FAIL rst_mid_precond: got line %b busy %b want 0 1", tx_line, tx_busy);
      else n_pass++;
      mon_en = 1'b0;
      #2 reset = 1'b0;
      #1;
      n_checks++;
      if (tx_line !== 1'b1 || tx_busy !== 1'b0)
         $display("FAIL rst_mid_async: got line %b busy %b want 1 0", tx_line, tx_busy);
      else n_pass++;
      read(A_STATUS, v, sel);
      n_checks++;
      if (v !== 32'h0000_0001)
         $display("FAIL rst_mid_fifo_empty: got %h want 00000001", v);
      else n_pass++;
      @(negedge clk);
      reset = 1'b1;
      mon_en = 1'b1;
      repeat (2 * FRAME) @(negedge clk);
      n_checks++;
      if (rx_q.size() != 0 || tx_line !== 1'b1 || tx_busy !== 1'b0)
         $display("FAIL rst_mid_no_residual: got frames %0d line %b busy %b want 0 1 0", rx_q.size(), tx_line, tx_busy);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_random();
      test_overflow();
      test_interrupt();
      test_decode_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
